// File: rtl/uart_pkg.sv
// Shared UART definitions: line-format encodings, the receive status word and
// the receive-FIFO occupancy states.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2,
    PAR_MARK = 2'd3
  } parity_mode_e;

  typedef enum logic [1:0] {
    DATA_BITS_5 = 2'd0,
    DATA_BITS_6 = 2'd1,
    DATA_BITS_7 = 2'd2,
    DATA_BITS_8 = 2'd3
  } data_bits_e;

  // Bit order is shared with the register block's status field.
  typedef struct packed {
    logic overrun;
    logic frame_err;
    logic parity_err;
    logic rx_timeout;
  } uart_status_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read. Contents
// are deliberately not reset.
module uart_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: circular FIFO with show-ahead read port, sticky error
// flags and level interrupt. Define UART_RX_FIFO_TIMEOUT_EN for the idle timeout.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  frame_error_in,
  input  logic                  parity_error_in,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      level,
  output logic                  empty,
  output logic                  full,
  input  logic [CNT_W-1:0]      threshold,
  output logic                  irq_level,
  input  logic                  err_clear,
  output logic                  overrun,
  output logic                  frame_err,
  output logic                  parity_err,
  input  logic [15:0]           timeout_cycles,
  output logic                  rx_timeout,
  output fifo_state_e           dbg_state
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LVL_FULL = CNT_W'(DEPTH);

  fifo_state_e       state_q;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  level_q;
  logic              irq_q;
  uart_status_t      status_q, status_d;
  logic              push, pop, drop;

  // Read port: a character transfers on any cycle with rd_valid && rd_ready;
  // rd_data is the head entry whenever rd_valid is high and does not depend on rd_ready.
  assign rd_valid = (state_q != ST_EMPTY);
  assign pop      = rd_valid && rd_ready;
  assign push     = wr_valid && ((state_q != ST_FULL) || pop);
  assign drop     = wr_valid && (state_q == ST_FULL) && !pop;

  uart_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      case ({push, pop})
        2'b10: begin
          level_q <= level_q + CNT_W'(1);
          state_q <= (level_q == LVL_FULL - CNT_W'(1)) ? ST_FULL : ST_PARTIAL;
        end
        2'b01: begin
          level_q <= level_q - CNT_W'(1);
          state_q <= (level_q == CNT_W'(1)) ? ST_EMPTY : ST_PARTIAL;
        end
        default: ;
      endcase
      // Compared against the registered level, so irq trails level by one cycle.
      irq_q <= (threshold != '0) && (level_q >= threshold);
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        tmo_hit;

  assign tmo_hit = rd_valid && !push && !pop && (timeout_cycles != 16'd0) &&
                   (16'(tmo_cnt_q + 16'd1) == timeout_cycles);

  always_ff @(posedge clk) begin
    if (reset || push || pop || !rd_valid) tmo_cnt_q <= '0;
    else if (tmo_cnt_q != 16'hFFFF)        tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
`endif

  // Set has priority over err_clear so a coincident error is never lost.
  always_comb begin
    status_d            = status_q;
    status_d.overrun    = drop            | (status_q.overrun    & ~err_clear);
    status_d.frame_err  = frame_error_in  | (status_q.frame_err  & ~err_clear);
    status_d.parity_err = parity_error_in | (status_q.parity_err & ~err_clear);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    status_d.rx_timeout = tmo_hit | (status_q.rx_timeout & ~pop & ~err_clear);
`else
    status_d.rx_timeout = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) status_q <= '0;
    else       status_q <= status_d;
  end

  assign level      = level_q;
  assign empty      = (state_q == ST_EMPTY);
  assign full       = (state_q == ST_FULL);
  assign irq_level  = irq_q;
  assign overrun    = status_q.overrun;
  assign frame_err  = status_q.frame_err;
  assign parity_err = status_q.parity_err;
  assign rx_timeout = status_q.rx_timeout;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, DATA_WIDTH=8).
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_valid;
  logic [DW-1:0]     wr_data;
  logic              frame_error_in, parity_error_in;
  logic              rd_ready;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;
  logic [CNT_W-1:0]  level;
  logic              empty, full;
  logic [CNT_W-1:0]  threshold;
  logic              irq_level;
  logic              err_clear;
  logic              overrun, frame_err, parity_err;
  logic [15:0]       timeout_cycles;
  logic              rx_timeout;
  fifo_state_e       dbg_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .wr_valid        (wr_valid),
    .wr_data         (wr_data),
    .frame_error_in  (frame_error_in),
    .parity_error_in (parity_error_in),
    .rd_ready        (rd_ready),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .level           (level),
    .empty           (empty),
    .full            (full),
    .threshold       (threshold),
    .irq_level       (irq_level),
    .err_clear       (err_clear),
    .overrun         (overrun),
    .frame_err       (frame_err),
    .parity_err      (parity_err),
    .timeout_cycles  (timeout_cycles),
    .rx_timeout      (rx_timeout),
    .dbg_state       (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) step();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0) begin
      failures++; $display("FAIL reset_flags empty=%b full=%b rd_valid=%b exp=1/0/0", empty, full, rd_valid); end
    checks++; if ({irq_level, overrun, frame_err, parity_err, rx_timeout} !== 5'b0) begin
      failures++; $display("FAIL reset_status got=%b exp=00000", {irq_level, overrun, frame_err, parity_err, rx_timeout}); end
    checks++; if (dbg_state !== ST_EMPTY) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_EMPTY); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_q[$];
    exp_q = '{8'h41, 8'h42, 8'h43};
    wr_valid = 1'b1; wr_data = 8'h41;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL no_bypass rd_valid=%b exp=0", rd_valid); end
    step(); wr_valid = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h41) begin
      failures++; $display("FAIL latency rd_valid=%b rd_data=%h exp=1/41", rd_valid, rd_data); end
    step(); push(8'h42); step(); push(8'h43); step();
    checks++; if (level !== 5'd3) begin failures++; $display("FAIL basic_level got=%0d exp=3", level); end
    checks++; if (rd_data !== 8'h41) begin failures++; $display("FAIL basic_head got=%h exp=41", rd_data); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_data !== exp_q[i]) begin failures++; $display("FAIL basic_read%0d got=%h exp=%h", i, rd_data, exp_q[i]); end
      step();
    end
    checks++; if (empty !== 1'b1 || level !== 5'd0) begin failures++; $display("FAIL basic_empty empty=%b level=%0d exp=1/0", empty, level); end
    step();
    rd_ready = 1'b0;
    checks++; if (level !== 5'd0 || dbg_state !== ST_EMPTY) begin
      failures++; $display("FAIL empty_read level=%0d state=%0d exp=0/%0d", level, dbg_state, ST_EMPTY); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    checks++; if (full !== 1'b1 || level !== 5'd16 || dbg_state !== ST_FULL) begin
      failures++; $display("FAIL fill full=%b level=%0d state=%0d exp=1/16/%0d", full, level, dbg_state, ST_FULL); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL fill_overrun got=%b exp=0", overrun); end
    push(8'hAA);
    checks++; if (overrun !== 1'b1 || level !== 5'd16) begin
      failures++; $display("FAIL overrun got=%b level=%0d exp=1/16", overrun, level); end
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (rd_data !== 8'(i)) begin failures++; $display("FAIL ovr_read%0d got=%h exp=%h", i, rd_data, 8'(i)); end
      step();
    end
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovr_empty got=%b exp=1", empty); end
    err_clear = 1'b1; step(); err_clear = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] exp_q[$];
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
    for (int i = 1; i < DEPTH; i++) exp_q.push_back(8'(8'h10 + i));
    exp_q.push_back(8'h55);
    wr_valid = 1'b1; wr_data = 8'h55; rd_ready = 1'b1;
    step();
    wr_valid = 1'b0; rd_ready = 1'b0;
    checks++; if (overrun !== 1'b0 || level !== 5'd16 || full !== 1'b1) begin
      failures++; $display("FAIL full_pp overrun=%b level=%0d full=%b exp=0/16/1", overrun, level, full); end
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (rd_data !== exp_q[i]) begin failures++; $display("FAIL pp_read%0d got=%h exp=%h", i, rd_data, exp_q[i]); end
      step();
    end
    rd_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL pp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_sticky();
    push(8'h77);
    frame_error_in = 1'b1; step(); frame_error_in = 1'b0;
    parity_error_in = 1'b1; step(); parity_error_in = 1'b0;
    checks++; if (frame_err !== 1'b1 || parity_err !== 1'b1 || level !== 5'd1) begin
      failures++; $display("FAIL sticky_set frame=%b parity=%b level=%0d exp=1/1/1", frame_err, parity_err, level); end
    err_clear = 1'b1; parity_error_in = 1'b1; step(); err_clear = 1'b0; parity_error_in = 1'b0;
    checks++; if (parity_err !== 1'b1 || frame_err !== 1'b0) begin
      failures++; $display("FAIL set_wins parity=%b frame=%b exp=1/0", parity_err, frame_err); end
    err_clear = 1'b1; step(); err_clear = 1'b0;
    checks++; if (parity_err !== 1'b0 || rd_data !== 8'h77) begin
      failures++; $display("FAIL sticky_clear parity=%b rd_data=%h exp=0/77", parity_err, rd_data); end
    drain(1);
  endtask

  task automatic test_irq();
    threshold = 5'd4;
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    checks++; if (level !== 5'd4 || irq_level !== 1'b0) begin
      failures++; $display("FAIL irq_lag level=%0d irq=%b exp=4/0", level, irq_level); end
    step();
    checks++; if (irq_level !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq_level); end
    drain(1);
    step();
    checks++; if (irq_level !== 1'b0 || level !== 5'd3) begin
      failures++; $display("FAIL irq_drop irq=%b level=%0d exp=0/3", irq_level, level); end
    threshold = 5'd0;
    push(8'hC9); step(); step();
    checks++; if (irq_level !== 1'b0) begin failures++; $display("FAIL irq_disabled got=%b exp=0", irq_level); end
    threshold = 5'd17;
    for (int i = 0; i < 12; i++) push(8'(i));
    step(); step();
    checks++; if (irq_level !== 1'b0 || full !== 1'b1) begin
      failures++; $display("FAIL irq_above_depth irq=%b full=%b exp=0/1", irq_level, full); end
    threshold = 5'd0;
    drain(DEPTH);
  endtask

  task automatic test_timeout();
`ifdef UART_RX_FIFO_TIMEOUT_EN
    timeout_cycles = 16'd100;
    push(8'h99);
    repeat (99) step();
    checks++; if (rx_timeout !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", rx_timeout); end
    step();
    checks++; if (rx_timeout !== 1'b1) begin failures++; $display("FAIL tmo_fire got=%b exp=1", rx_timeout); end
    drain(1);
    checks++; if (rx_timeout !== 1'b0) begin failures++; $display("FAIL tmo_pop_clear got=%b exp=0", rx_timeout); end
    repeat (150) step();
    checks++; if (rx_timeout !== 1'b0) begin failures++; $display("FAIL tmo_empty got=%b exp=0", rx_timeout); end
    timeout_cycles = 16'd0;
`else
    timeout_cycles = 16'd5;
    push(8'h99);
    repeat (120) step();
    checks++; if (rx_timeout !== 1'b0) begin failures++; $display("FAIL tmo_tied got=%b exp=0", rx_timeout); end
    drain(1);
    timeout_cycles = 16'd0;
`endif
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) push(8'(8'hE0 + i));
    frame_error_in = 1'b1; step(); frame_error_in = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (level !== 5'd0 || rd_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL mid_reset level=%0d rd_valid=%b frame=%b exp=0/0/0", level, rd_valid, frame_err); end
    push(8'h3C);
    checks++; if (rd_data !== 8'h3C || level !== 5'd1) begin
      failures++; $display("FAIL post_reset rd_data=%h level=%0d exp=3c/1", rd_data, level); end
    drain(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0;
    frame_error_in = 1'b0; parity_error_in = 1'b0;
    rd_ready = 1'b0; threshold = '0; err_clear = 1'b0; timeout_cycles = '0;
    test_reset();
    test_basic();
    test_overrun();
    test_full_push_pop();
    test_sticky();
    test_irq();
    test_timeout();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
